// File: rtl/dc_filter_mc.sv
// Time-multiplexed multi-channel DC-blocking filter: one shared leaky-integrator datapath stepped across N_CH channels.
// Build option: define DC_FILTER_MC_SAT_EN to saturate outputs; otherwise outputs wrap to DATA_W bits.
module dc_filter_mc #(
    parameter int DATA_W  = 9,
    parameter int N_CH    = 4,
    parameter int K_SHIFT = 10
) (
    input  logic                     CLK_24M,
    input  logic                     reset,
    input  logic                     enable_3M,
    input  logic [N_CH*DATA_W-1:0]   c_data,
    input  logic                     freeze,
    output logic [N_CH*DATA_W-1:0]   o_data,
    output logic                     o_valid,
    output logic                     busy,
    output logic                     overrun
);

    // state | meaning
    // IDLE  | waiting for enable_3M, captures c_data
    // CALC  | one channel per cycle, idx_q = channel
    // DONE  | publish results, pulse o_valid
    localparam int ACC_W = DATA_W + K_SHIFT + 1;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [N_CH*DATA_W-1:0]   x_q, x_d;
    logic [N_CH*DATA_W-1:0]   res_q, res_d;
    logic [N_CH*DATA_W-1:0]   o_data_q, o_data_d;
    logic                     o_valid_q, o_valid_d;
    logic                     overrun_q, overrun_d;
    logic signed [ACC_W-1:0]  acc_q [N_CH];

    logic signed [DATA_W-1:0] x_cur;
    logic signed [ACC_W-1:0]  acc_cur;
    logic signed [ACC_W-1:0]  dc_full;
    logic signed [ACC_W-1:0]  acc_next;
    logic [DATA_W-1:0]        y_red;
    logic                     acc_we;

    always_comb begin
        x_cur    = x_q[int'(idx_q)*DATA_W +: DATA_W];
        acc_cur  = acc_q[idx_q];
        dc_full  = acc_cur >>> K_SHIFT;
        acc_next = acc_cur + ACC_W'(x_cur) - dc_full;
    end

`ifdef DC_FILTER_MC_SAT_EN
    localparam int Y_W = DATA_W + 1;
    localparam logic signed [Y_W-1:0] Y_MAX = Y_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [Y_W-1:0] Y_MIN = Y_W'(-(1 << (DATA_W - 1)));
    logic signed [Y_W-1:0] y_full;

    always_comb begin
        y_full = Y_W'(x_cur) - dc_full[Y_W-1:0];
        if (y_full > Y_MAX) begin
            y_red = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (y_full < Y_MIN) begin
            y_red = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            y_red = y_full[DATA_W-1:0];
        end
    end
`else
    // Low DATA_W bits of the DATA_W+1 difference are all a wrapping output needs.
    always_comb begin
        y_red = x_cur - dc_full[DATA_W-1:0];
    end
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        x_d       = x_q;
        res_d     = res_q;
        o_data_d  = o_data_q;
        o_valid_d = 1'b0;
        overrun_d = overrun_q;
        acc_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_3M) begin
                    x_d     = c_data;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d[int'(idx_q)*DATA_W +: DATA_W] = y_red;
                acc_we = !freeze;
                if (enable_3M) overrun_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                o_data_d  = res_q;
                o_valid_d = 1'b1;
                if (enable_3M) overrun_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_24M) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            x_q       <= '0;
            res_q     <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) acc_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            res_q     <= res_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            overrun_q <= overrun_d;
            if (acc_we) acc_q[idx_q] <= acc_next;
        end
    end

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
    assign overrun = overrun_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dc_filter_mc.sv
// Bench for dc_filter_mc (DATA_W=9, N_CH=4, K_SHIFT=4): vector table plus scoreboard-checked multi-cycle sequences.
module tb_dc_filter_mc;
    localparam int DW = 9;
    localparam int NC = 4;
    localparam int KS = 4;
    localparam int DIV = 1 << KS;
    localparam int HALF = 1 << (DW - 1);

    typedef logic [NC-1:0][15:0] vec_t;
    typedef struct {
        vec_t x;
        bit   frz;
        vec_t exp;
    } vec_rec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable_3M = 1'b0;
    logic [NC*DW-1:0] c_data = '0;
    logic             freeze = 1'b0;
    logic [NC*DW-1:0] o_data;
    logic             o_valid;
    logic             busy;
    logic             overrun;

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_valid = 0;
    int   macc [NC];
    int   last_out [NC];
    vec_t sb_q [$];
    vec_rec_t tbl [5];

    dc_filter_mc #(.DATA_W(DW), .N_CH(NC), .K_SHIFT(KS)) dut (
        .CLK_24M(clk), .reset(reset), .enable_3M(enable_3M), .c_data(c_data),
        .freeze(freeze), .o_data(o_data), .o_valid(o_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d);
        vec_t v;
        v[0] = 16'(a); v[1] = 16'(b); v[2] = 16'(c); v[3] = 16'(d);
        return v;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NC; i++) macc[i] = 0;
    endfunction

    // Reference: floor division for dc, clamp or modular wrap for the output.
    function automatic vec_t model_step(input vec_t x, input bit frz);
        vec_t r;
        int xi, dc, y, o;
        for (int i = 0; i < NC; i++) begin
            xi = int'($signed(x[i]));
            if (macc[i] >= 0) dc = macc[i] / DIV;
            else dc = -((-macc[i] + DIV - 1) / DIV);
            y = xi - dc;
`ifdef DC_FILTER_MC_SAT_EN
            o = (y > HALF - 1) ? HALF - 1 : ((y < -HALF) ? -HALF : y);
`else
            o = ((y % (2 * HALF)) + 3 * HALF) % (2 * HALF) - HALF;
`endif
            r[i] = 16'(o);
            if (!frz) macc[i] += y;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        vec_t e;
        int a;
        #1;
        if (o_valid) begin
            n_valid++;
            chk("valid_expected", longint'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int i = 0; i < NC; i++) begin
                    a = int'($signed(o_data[i*DW +: DW]));
                    last_out[i] = a;
                    chk($sformatf("out_ch%0d", i), a, int'($signed(e[i])));
                end
            end
        end
    end

    task automatic drive_x(input vec_t x);
        for (int i = 0; i < NC; i++) c_data[i*DW +: DW] = x[i][DW-1:0];
    endtask

    task automatic send(input vec_t x, input bit frz, input vec_t e);
        @(negedge clk);
        drive_x(x);
        freeze = frz;
        enable_3M = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1 enable_3M = 1'b0;
        repeat (7) @(posedge clk);
    endtask

    task automatic send_m(input vec_t x, input bit frz);
        vec_t e;
        e = model_step(x, frz);
        send(x, frz, e);
    endtask

    task automatic apply_reset();
        chk("sb_drained", sb_q.size(), 0);
        @(negedge clk);
        reset = 1'b1;
        enable_3M = 1'b0;
        freeze = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, p0, p1, nv;
        bit mono;
        vec_t e;

        tbl[0] = '{x: mk(37, -5, 255, -256), frz: 1'b0, exp: mk(37, -5, 255, -256)};
        tbl[1] = '{x: mk(37, -5, 255, -256), frz: 1'b0, exp: mk(35, -4, 240, -240)};
        tbl[2] = '{x: mk(0, 0, 0, 0),        frz: 1'b0, exp: mk(-4, 1, -30, 31)};
`ifdef DC_FILTER_MC_SAT_EN
        tbl[3] = '{x: mk(-256, 255, -256, 255), frz: 1'b1, exp: mk(-256, 255, -256, 255)};
`else
        tbl[3] = '{x: mk(-256, 255, -256, 255), frz: 1'b1, exp: mk(252, -256, 227, -227)};
`endif
        tbl[4] = '{x: mk(10, 10, 10, 10),    frz: 1'b0, exp: mk(6, 11, -19, 40)};

        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_o_data", longint'(o_data), 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);

        // Latency: strobe sampled at edge t0, values observed just after each edge.
        @(negedge clk);
        drive_x(mk(37, 0, 0, 0));
        enable_3M = 1'b1;
        e = model_step(mk(37, 0, 0, 0), 1'b0);
        sb_q.push_back(e);
        @(posedge clk);
        #1 enable_3M = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("lat_busy_t%0d", k + 1), busy, (k <= NC) ? 1 : 0);
            chk($sformatf("lat_valid_t%0d", k + 1), o_valid, (k == NC + 1) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        chk("lat_ch0", last_out[0], 37);

        apply_reset();
        for (int i = 0; i < 5; i++) begin
            void'(model_step(tbl[i].x, tbl[i].frz));
            send(tbl[i].x, tbl[i].frz, tbl[i].exp);
        end

        // DC removal on constant inputs.
        apply_reset();
        mono = 1'b1;
        p0 = 1000; p1 = 1000;
        for (int n = 0; n < 160; n++) begin
            send_m(mk(100, -100, 0, 0), 1'b0);
            if (n == 0) begin
                chk("dc_first_ch0", last_out[0], 100);
                chk("dc_first_ch1", last_out[1], -100);
            end
            if ((last_out[0] < 0 ? -last_out[0] : last_out[0]) > p0) mono = 1'b0;
            if ((last_out[1] < 0 ? -last_out[1] : last_out[1]) > p1) mono = 1'b0;
            p0 = last_out[0] < 0 ? -last_out[0] : last_out[0];
            p1 = last_out[1] < 0 ? -last_out[1] : last_out[1];
        end
        chk("dc_monotonic", mono, 1);
        chk("dc_final_ch0", last_out[0], 0);
        chk("dc_final_ch1", last_out[1], 0);
        a0 = int'($signed(dut.acc_q[0]));
        a1 = int'($signed(dut.acc_q[1]));
        chk("dc_acc0_range", longint'(a0 >= 1600 && a0 <= 1615), 1);
        chk("dc_acc1_range", longint'(a1 >= -1600 && a1 <= -1585), 1);

        // Freeze after settling: dc held at 100, so 120 yields 20 each sample.
        for (int n = 0; n < 5; n++) begin
            send_m(mk(120, -100, 0, 0), 1'b1);
            chk("frz_ch0", last_out[0], 20);
        end
        chk("frz_acc0_held", int'($signed(dut.acc_q[0])), a0);
        chk("frz_acc1_held", int'($signed(dut.acc_q[1])), a1);

        // Saturation/wrap on a full-scale step.
        apply_reset();
        for (int n = 0; n < 200; n++) send_m(mk(-256, 0, 0, 0), 1'b0);
        chk("sat_settled", last_out[0], 0);
        send_m(mk(255, 0, 0, 0), 1'b0);
`ifdef DC_FILTER_MC_SAT_EN
        chk("sat_step", last_out[0], 255);
`else
        chk("sat_step", last_out[0], -1);
`endif

        // Overrun: second strobe lands in CALC and is dropped.
        apply_reset();
        chk("ovr_clear", overrun, 0);
        nv = n_valid;
        @(negedge clk);
        drive_x(mk(11, 12, 13, 14));
        enable_3M = 1'b1;
        e = model_step(mk(11, 12, 13, 14), 1'b0);
        sb_q.push_back(e);
        @(posedge clk);
        #1 enable_3M = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive_x(mk(-90, -91, -92, -93));
        enable_3M = 1'b1;
        @(posedge clk);
        #1 enable_3M = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("ovr_set", overrun, 1);
        chk("ovr_one_valid", n_valid - nv, 1);
        send_m(mk(1, 2, 3, 4), 1'b0);
        chk("ovr_sticky", overrun, 1);
        apply_reset();
        chk("ovr_reset", overrun, 0);

        // Reset sampled at edge t0+2 aborts the sequence.
        send_m(mk(33, 33, 33, 33), 1'b0);
        chk("mid_pre_nonzero", longint'(o_data != 0), 1);
        @(negedge clk);
        drive_x(mk(77, 77, 77, 77));
        enable_3M = 1'b1;
        @(posedge clk);
        #1 enable_3M = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        nv = n_valid;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_no_valid", n_valid - nv, 0);
        chk("mid_o_data", longint'(o_data), 0);
        chk("mid_busy", busy, 0);
        send_m(mk(50, 50, 50, 50), 1'b0);
        chk("mid_next_ch0", last_out[0], 50);
        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
